// File: rtl/iob_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_bus_arbiter_pkg
// Brief    : Shared types and bundle-width helpers for the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package iob_bus_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Request bundle is {valid, address, wdata, wstrb}, valid in the MSB.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response bundle is {rdata, ready}, ready in the LSB.
  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_bus_arbiter_if
// Brief    : Requester-side and slave-side bundles around the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface iob_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  import iob_bus_arbiter_pkg::*;

  localparam int REQ_W  = req_width(ADDR_W, DATA_W);
  localparam int RESP_W = resp_width(DATA_W);
  localparam int IDX_W  = idx_width(N_MASTERS);

  logic [N_MASTERS*REQ_W-1:0]  m_req;
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;
  logic [IDX_W-1:0]            grant;
  logic                        busy;

  // slave: the arbiter's view; master: the surrounding requesters and memory.
  modport slave  (input  m_req, s_resp, output m_resp, s_req, grant, busy);
  modport master (output m_req, s_resp, input  m_resp, s_req, grant, busy);

endinterface
`default_nettype wire

// File: rtl/iob_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : iob_rr_pick
// Brief    : Combinational rotating-priority picker (first valid at/after ptr).
// Revision : 1.0 - initial release
// ============================================================================
module iob_rr_pick #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     prio_ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_valid
);

  // Walk offsets from farthest to nearest so the nearest valid entry wins.
  always_comb begin : p_pick
    logic [IDX_W:0] idx;
    winner    = '0;
    any_valid = |req;
    idx       = '0;
    for (int off = N_MASTERS - 1; off >= 0; off--) begin
      idx = {1'b0, prio_ptr} + (IDX_W+1)'(off);
      if (idx > (IDX_W+1)'(N_MASTERS - 1)) begin
        idx = idx - (IDX_W+1)'(N_MASTERS);
      end
      if (req[idx[IDX_W-1:0]]) begin
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iob_bus_arbiter
// Brief    : Round-robin arbiter sharing one native-interface slave.
// Revision : 1.0 - initial release
// ============================================================================
module iob_bus_arbiter
  import iob_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  iob_bus_arbiter_if.slave  bus
);

  localparam int REQ_W  = req_width(ADDR_W, DATA_W);
  localparam int RESP_W = resp_width(DATA_W);
  localparam int IDX_W  = idx_width(N_MASTERS);
  localparam int LAT_W  = REQ_W - 1;

  arb_state_e           state_q, state_d;
  logic                 s_valid_q, s_valid_d;
  logic [LAT_W-1:0]     req_q, req_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     prio_ptr_q, prio_ptr_d;

  logic [N_MASTERS-1:0] m_valid;
  logic [IDX_W-1:0]     winner;
  logic                 any_valid;
  logic                 s_ready;
  logic [LAT_W-1:0]     winner_fields;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
    assign m_valid[i] = bus.m_req[i*REQ_W + REQ_W - 1];
  end

  assign s_ready = bus.s_resp[0];

  iob_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req       (m_valid),
    .prio_ptr  (prio_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    winner_fields = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (winner == IDX_W'(i)) begin
        winner_fields = bus.m_req[i*REQ_W +: LAT_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    s_valid_d  = s_valid_q;
    req_d      = req_q;
    grant_d    = grant_q;
    prio_ptr_d = prio_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d   = winner;
          req_d     = winner_fields;
          s_valid_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Returning to IDLE for a cycle keeps the just-served stale valid from re-winning.
        if (s_ready) begin
          s_valid_d  = 1'b0;
          state_d    = ST_IDLE;
          prio_ptr_d = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.m_resp = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if ((state_q == ST_BUSY) && s_ready && (grant_q == IDX_W'(i))) begin
        bus.m_resp[i*RESP_W +: RESP_W] = bus.s_resp;
      end
    end
  end

  assign bus.s_req = {s_valid_q, req_q};
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_valid_q  <= 1'b0;
      req_q      <= '0;
      grant_q    <= '0;
      prio_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      req_q      <= req_d;
      grant_q    <= grant_d;
      prio_ptr_q <= prio_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_bus_arbiter
// Brief    : Directed plus random bench for iob_bus_arbiter with 3 masters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_bus_arbiter;

  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int REQ_W  = 1 + AW + DW + SW;
  localparam int RESP_W = DW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iob_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  iob_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Transaction-level reference: per-master request queues plus one in-flight slot.
  req_t mq[N][$];
  bit   hide[N];
  bit   drop[N];
  bit   mdl_busy;
  int   mdl_grant, mdl_ptr, wcnt, cur_k, fixed_k;
  bit   rand_k, rogue;
  req_t mdl_req;
  int   acc_cyc[$];

  int          obs_sval, obs_busy;
  int          obs_rdy_cnt[N], obs_rdy_first[N];
  logic [DW-1:0] obs_rdata[N];
  logic [REQ_W-1:0] obs_sreq_rdy;
  int          gnt_log[$], rise_cyc[$];
  bit          prev_busy;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {4{a[7:0]}};
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_busy  = 1'b0;
    mdl_grant = 0;
    mdl_ptr   = 0;
    wcnt      = 0;
    mdl_req   = '0;
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      hide[i] = 1'b0;
    end
  endtask

  task automatic clr_obs();
    obs_sval = 0;
    obs_busy = 0;
    obs_sreq_rdy = '0;
    for (int i = 0; i < N; i++) begin
      obs_rdy_cnt[i]   = 0;
      obs_rdy_first[i] = -1;
      obs_rdata[i]     = '0;
    end
    gnt_log.delete();
    rise_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic push(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s;
    mq[m].push_back(r);
  endtask

  task automatic cycle(input bit do_rst);
    bit                  vld[N];
    logic [REQ_W-1:0]    sl;
    bit                  s_rdy, found;
    logic [DW-1:0]       s_rd;
    logic [N*RESP_W-1:0] exp_resp;
    int                  w, idx;
    @(posedge clk);
    #1;
    cyc++;
    rst = do_rst;
    for (int i = 0; i < N; i++) begin
      if (hide[i]) begin
        vld[i] = 1'b0;
        sl = {1'b0, $urandom, $urandom, 4'($urandom)};
      end else if (mq[i].size() > 0) begin
        vld[i] = 1'b1;
        sl = {1'b1, mq[i][0]};
      end else begin
        vld[i] = 1'b0;
        sl = '0;
      end
      bus.m_req[i*REQ_W +: REQ_W] = sl;
    end
    s_rdy = rogue || (mdl_busy && (wcnt == cur_k));
    s_rd  = s_rdy ? (mdl_busy ? rdata_of(mdl_req.addr) : 32'h5A5A_5A5A) : '0;
    bus.s_resp = {s_rd, s_rdy};
    #1;
    exp_resp = '0;
    if (mdl_busy && s_rdy) exp_resp[mdl_grant*RESP_W +: RESP_W] = {s_rd, 1'b1};
    chk("busy",   bus.busy,  mdl_busy);
    chk("grant",  bus.grant, mdl_grant);
    chk("s_req",  bus.s_req, {mdl_busy, mdl_req});
    chk("m_resp", bus.m_resp, exp_resp);
    for (int i = 0; i < N; i++) begin
      if (bus.m_resp[i*RESP_W] === 1'b1) begin
        if (obs_rdy_cnt[i] == 0) obs_rdy_first[i] = cyc;
        obs_rdy_cnt[i]++;
        obs_rdata[i] = bus.m_resp[i*RESP_W+1 +: DW];
        obs_sreq_rdy = bus.s_req;
      end
    end
    if (bus.s_req[REQ_W-1] === 1'b1) obs_sval++;
    if (bus.busy === 1'b1) obs_busy++;
    if ((bus.busy === 1'b1) && !prev_busy) begin
      gnt_log.push_back(int'(bus.grant));
      rise_cyc.push_back(cyc);
    end
    prev_busy = (bus.busy === 1'b1);
    if (do_rst) begin
      mdl_reset();
    end else if (mdl_busy) begin
      if (s_rdy) begin
        mdl_busy = 1'b0;
        mdl_ptr  = (mdl_grant + 1) % N;
        if (mq[mdl_grant].size() > 0) void'(mq[mdl_grant].pop_front());
        hide[mdl_grant] = 1'b0;
      end else begin
        wcnt++;
      end
    end else begin
      found = 1'b0;
      w     = 0;
      for (int j = 0; j < N; j++) begin
        idx = (mdl_ptr + j) % N;
        if (!found && vld[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
      if (found) begin
        mdl_busy  = 1'b1;
        mdl_grant = w;
        mdl_req   = mq[w][0];
        wcnt      = 0;
        cur_k     = rand_k ? int'($urandom_range(0, 3)) : fixed_k;
        if (drop[w]) hide[w] = 1'b1;
        acc_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic drain(input string tag, input int limit);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    while (!done && n < limit) begin
      cycle(1'b0);
      n++;
      done = !mdl_busy && (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0);
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst        = 1'b1;
    bus.m_req  = '0;
    bus.s_resp = '0;
    fixed_k    = 0;
    cur_k      = 0;
    rand_k     = 1'b0;
    rogue      = 1'b0;
    prev_busy  = 1'b0;
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    mdl_reset();
    clr_obs();
    repeat (3) @(posedge clk);

    // Reset state checked by the model, then a single write with a 2-cycle slave.
    cycle(1'b0);
    fixed_k = 2;
    push(0, 32'h100, 32'hDEAD_BEEF, 4'hF);
    run(8);
    t = at(acc_cyc, 0);
    chk("t1_sval_cycles", obs_sval, 3);
    chk("t1_m0_ready_cnt", obs_rdy_cnt[0], 1);
    chk("t1_m0_ready_cyc", obs_rdy_first[0], t + 3);
    chk("t1_m1_ready_cnt", obs_rdy_cnt[1], 0);
    chk("t1_grant", at(gnt_log, 0), 0);

    // Contention after reset, then a probe of the rotated pointer.
    cycle(1'b1);
    clr_obs();
    fixed_k = 1;
    push(0, 32'h11, 32'h0, 4'h0);
    push(1, 32'h22, 32'h0, 4'h0);
    run(12);
    t = at(acc_cyc, 0);
    chk("t2_m0_ready_cyc", obs_rdy_first[0], t + 2);
    chk("t2_m1_ready_cyc", obs_rdy_first[1], t + 5);
    chk("t2_m1_svalid_cyc", at(rise_cyc, 1), t + 4);
    chk("t2_m0_rdata", obs_rdata[0], 32'h1111_1111);
    chk("t2_m1_rdata", obs_rdata[1], 32'h2222_2222);
    chk("t2_first", at(gnt_log, 0), 0);
    chk("t2_second", at(gnt_log, 1), 1);
    push(0, 32'h33, 32'h0, 4'h0);
    push(2, 32'h44, 32'h0, 4'h0);
    run(12);
    chk("t2_ptr_third", at(gnt_log, 2), 2);
    chk("t2_ptr_fourth", at(gnt_log, 3), 0);

    // All three masters continuously requesting.
    cycle(1'b1);
    clr_obs();
    fixed_k = 1;
    for (int r = 0; r < 3; r++)
      for (int m = 0; m < N; m++) push(m, $urandom, $urandom, 4'($urandom));
    drain("t3_drain", 100);
    chk("t3_count", gnt_log.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t3_grant%0d", i), at(gnt_log, i), i % 3);

    // Zero-wait slave, back-to-back requests from one master.
    clr_obs();
    fixed_k = 0;
    push(2, 32'h55, 32'h0, 4'h0);
    push(2, 32'h66, 32'h1, 4'h1);
    run(10);
    t = at(acc_cyc, 0);
    chk("t4_svalid_cyc", at(rise_cyc, 0), t + 1);
    chk("t4_ready_cyc", obs_rdy_first[2], t + 1);
    chk("t4_busy_cycles", obs_busy, 2);
    chk("t4_next_svalid", at(rise_cyc, 1), t + 3);
    chk("t4_ready_cnt", obs_rdy_cnt[2], 2);

    // Master abandons valid after grant while slave stalls 3 cycles.
    clr_obs();
    fixed_k = 3;
    drop[1] = 1'b1;
    push(1, 32'hABC0, 32'h1234_5678, 4'h3);
    run(10);
    drop[1] = 1'b0;
    chk("t5_ready_cnt", obs_rdy_cnt[1], 1);
    chk("t5_sval_cycles", obs_sval, 4);
    chk("t5_sreq_latched", obs_sreq_rdy, {1'b1, 32'hABC0, 32'h1234_5678, 4'h3});

    // Reset in the middle of a stalled transaction, then a late slave ready.
    clr_obs();
    fixed_k = 50;
    push(2, 32'h77, 32'h0, 4'h0);
    run(4);
    cycle(1'b1);
    cycle(1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_svalid", bus.s_req[REQ_W-1], 1'b0);
    chk("t6_grant", bus.grant, 0);
    chk("t6_mresp", bus.m_resp, '0);
    rogue = 1'b1;
    run(2);
    rogue = 1'b0;
    chk("t6_no_fwd", obs_rdy_cnt[0] + obs_rdy_cnt[1] + obs_rdy_cnt[2], 0);

    // Random traffic with random slave waits and occasional abandoned valids.
    cycle(1'b1);
    rand_k = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        if (mq[m].size() < 2 && $urandom_range(0, 2) == 0) begin
          if (mq[m].size() == 0) drop[m] = ($urandom_range(0, 5) == 0);
          push(m, $urandom, $urandom, 4'($urandom));
        end
      end
      cycle(1'b0);
    end
    drain("t7_drain", 200);
    rand_k = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
